// File: rtl/noc_pipeline_link_if.sv
// Flit/credit bundle for one direction of a NoC link.
// master drives flit, destination, tail and send, and receives credit.
// slave receives flit, destination, tail and send, and drives credit.
interface noc_pipeline_link_if #(
    parameter int FLIT_WIDTH = 64,
    parameter int DEST_WIDTH = 4
);
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  is_tail;
    logic                  send;
    logic                  credit;

    modport master (output data, output dest, output is_tail, output send, input credit);
    modport slave  (input data, input dest, input is_tail, input send, output credit);
endinterface

// File: rtl/noc_pipeline_link.sv
// noc_pipeline_link: registered, credit-based link stage between two routers.
//
// The forward path carries {data, dest, is_tail, send} through NUM_PIPELINE
// register slices. The reverse path carries credit through the same number
// of slices. With NUM_PIPELINE = 0 both paths are plain wires.
//
// Optional upstream monitor, built only when NOC_LINK_MONITOR_EN is defined.
// It tracks credits, packet framing and sticky protocol errors. Without the
// macro, credits_avail is tied to FLIT_BUFFER_DEPTH and the flags are tied to 0.
module noc_pipeline_link #(
    parameter int NUM_PIPELINE      = 0,
    parameter int FLIT_WIDTH        = 64,
    parameter int DEST_WIDTH        = 4,
    parameter int FLIT_BUFFER_DEPTH = 1
) (
    input  logic                                       clk_noc,
    input  logic                                       rst_n,
    noc_pipeline_link_if.slave                         up_if,
    noc_pipeline_link_if.master                        dn_if,
    output logic [$clog2(FLIT_BUFFER_DEPTH+1)-1:0]     credits_avail,
    output logic                                       pkt_open,
    output logic                                       err_no_credit,
    output logic                                       err_credit_ovf
);

    localparam int                  CNT_W   = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam int                  FWD_W   = FLIT_WIDTH + DEST_WIDTH + 2;
    localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(FLIT_BUFFER_DEPTH);
    localparam logic [CNT_W-1:0]    ONE_C   = CNT_W'(1);

    // Credit as seen on the upstream side; the monitor samples this.
    logic credit_up_s;

    assign up_if.credit = credit_up_s;

    generate
        if (NUM_PIPELINE == 0) begin : g_pass
            assign dn_if.data    = up_if.data;
            assign dn_if.dest    = up_if.dest;
            assign dn_if.is_tail = up_if.is_tail;
            assign dn_if.send    = up_if.send;
            assign credit_up_s   = dn_if.credit;
        end else begin : g_pipe
            // Slice 0 is nearest the input. Slice NUM_PIPELINE-1 drives the output.
            logic [NUM_PIPELINE-1:0][FWD_W-1:0] fwd_q;
            logic [NUM_PIPELINE-1:0]            crd_q;

            // Free-running shift registers; reset drops everything in flight.
            always_ff @(posedge clk_noc or negedge rst_n) begin
                if (!rst_n) begin
                    fwd_q <= '0;
                    crd_q <= '0;
                end else begin
                    fwd_q[0] <= {up_if.data, up_if.dest, up_if.is_tail, up_if.send};
                    crd_q[0] <= dn_if.credit;
                    for (int i = 1; i < NUM_PIPELINE; i++) begin
                        fwd_q[i] <= fwd_q[i-1];
                        crd_q[i] <= crd_q[i-1];
                    end
                end
            end

            assign {dn_if.data, dn_if.dest, dn_if.is_tail, dn_if.send} = fwd_q[NUM_PIPELINE-1];
            assign credit_up_s = crd_q[NUM_PIPELINE-1];
        end
    endgenerate

`ifdef NOC_LINK_MONITOR_EN
    logic [CNT_W-1:0] credits_q, credits_d;
    logic             pkt_q, pkt_d;
    logic             err_nc_q, err_nc_d;
    logic             err_ovf_q, err_ovf_d;

    // Next-state for the credit counter, framing tracker and sticky errors.
    always_comb begin
        credits_d = credits_q;
        pkt_d     = pkt_q;
        err_nc_d  = err_nc_q;
        err_ovf_d = err_ovf_q;
        case ({up_if.send, credit_up_s})
            2'b10: begin
                if (credits_q == '0) begin
                    err_nc_d = 1'b1;
                end else begin
                    credits_d = credits_q - ONE_C;
                end
            end
            2'b01: begin
                if (credits_q == DEPTH_C) begin
                    err_ovf_d = 1'b1;
                end else begin
                    credits_d = credits_q + ONE_C;
                end
            end
            default: begin
                credits_d = credits_q;
            end
        endcase
        if (up_if.send) begin
            pkt_d = ~up_if.is_tail;
        end else begin
            pkt_d = pkt_q;
        end
    end

    // Monitor state registers.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            credits_q <= DEPTH_C;
            pkt_q     <= 1'b0;
            err_nc_q  <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            credits_q <= credits_d;
            pkt_q     <= pkt_d;
            err_nc_q  <= err_nc_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    assign credits_avail  = credits_q;
    assign pkt_open       = pkt_q;
    assign err_no_credit  = err_nc_q;
    assign err_credit_ovf = err_ovf_q;
`else
    assign credits_avail  = DEPTH_C;
    assign pkt_open       = 1'b0;
    assign err_no_credit  = 1'b0;
    assign err_credit_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_noc_pipeline_link.sv
// Bench for noc_pipeline_link. Three instances (latency 0, 3 and 4, buffer
// depth 2) share one stimulus stream. A history of applied inputs plus a
// credit/framing model gives the expected outputs of every instance each cycle.
module tb_noc_pipeline_link;

`ifdef NOC_LINK_MONITOR_EN
    localparam bit MON_EN = 1'b1;
`else
    localparam bit MON_EN = 1'b0;
`endif
    localparam int DEPTH = 2;
    localparam int HMAX  = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] data_in = '0;
    logic [3:0]  dest_in = '0;
    logic        tail_in = 1'b0;
    logic        send_in = 1'b0;
    logic        credit_in = 1'b0;

    always #5 clk = ~clk;

    noc_pipeline_link_if #(.FLIT_WIDTH(64), .DEST_WIDTH(4)) up0 ();
    noc_pipeline_link_if #(.FLIT_WIDTH(64), .DEST_WIDTH(4)) dn0 ();
    noc_pipeline_link_if #(.FLIT_WIDTH(64), .DEST_WIDTH(4)) up3 ();
    noc_pipeline_link_if #(.FLIT_WIDTH(64), .DEST_WIDTH(4)) dn3 ();
    noc_pipeline_link_if #(.FLIT_WIDTH(64), .DEST_WIDTH(4)) up4 ();
    noc_pipeline_link_if #(.FLIT_WIDTH(64), .DEST_WIDTH(4)) dn4 ();

    assign up0.data = data_in; assign up0.dest = dest_in; assign up0.is_tail = tail_in; assign up0.send = send_in;
    assign up3.data = data_in; assign up3.dest = dest_in; assign up3.is_tail = tail_in; assign up3.send = send_in;
    assign up4.data = data_in; assign up4.dest = dest_in; assign up4.is_tail = tail_in; assign up4.send = send_in;
    assign dn0.credit = credit_in;
    assign dn3.credit = credit_in;
    assign dn4.credit = credit_in;

    logic [1:0]  ca [3];
    logic        pk [3];
    logic        nc [3];
    logic        ov [3];
    logic [63:0] o_data [3];
    logic [3:0]  o_dest [3];
    logic        o_tail [3];
    logic        o_send [3];
    logic        o_cred [3];

    assign o_data[0] = dn0.data; assign o_dest[0] = dn0.dest; assign o_tail[0] = dn0.is_tail;
    assign o_send[0] = dn0.send; assign o_cred[0] = up0.credit;
    assign o_data[1] = dn3.data; assign o_dest[1] = dn3.dest; assign o_tail[1] = dn3.is_tail;
    assign o_send[1] = dn3.send; assign o_cred[1] = up3.credit;
    assign o_data[2] = dn4.data; assign o_dest[2] = dn4.dest; assign o_tail[2] = dn4.is_tail;
    assign o_send[2] = dn4.send; assign o_cred[2] = up4.credit;

    noc_pipeline_link #(.NUM_PIPELINE(0), .FLIT_WIDTH(64), .DEST_WIDTH(4), .FLIT_BUFFER_DEPTH(DEPTH)) u_p0 (
        .clk_noc(clk), .rst_n(rst_n), .up_if(up0), .dn_if(dn0),
        .credits_avail(ca[0]), .pkt_open(pk[0]), .err_no_credit(nc[0]), .err_credit_ovf(ov[0]));
    noc_pipeline_link #(.NUM_PIPELINE(3), .FLIT_WIDTH(64), .DEST_WIDTH(4), .FLIT_BUFFER_DEPTH(DEPTH)) u_p3 (
        .clk_noc(clk), .rst_n(rst_n), .up_if(up3), .dn_if(dn3),
        .credits_avail(ca[1]), .pkt_open(pk[1]), .err_no_credit(nc[1]), .err_credit_ovf(ov[1]));
    noc_pipeline_link #(.NUM_PIPELINE(4), .FLIT_WIDTH(64), .DEST_WIDTH(4), .FLIT_BUFFER_DEPTH(DEPTH)) u_p4 (
        .clk_noc(clk), .rst_n(rst_n), .up_if(up4), .dn_if(dn4),
        .credits_avail(ca[2]), .pkt_open(pk[2]), .err_no_credit(nc[2]), .err_credit_ovf(ov[2]));

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  dest;
        logic        tail;
        logic        send;
        logic        credit;
    } in_t;

    in_t hist [HMAX];
    int  cyc;
    int  m_cr  [3];
    bit  m_pkt [3];
    bit  m_nc  [3];
    bit  m_ovf [3];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic int lat_of(input int k);
        if (k == 0) return 0;
        else if (k == 1) return 3;
        else return 4;
    endfunction

    // What instance k presents during the current cycle: the input applied
    // lat cycles ago, or all zeros if that is before the last reset.
    function automatic in_t delayed(input int k);
        in_t z;
        z = '0;
        if (cyc >= lat_of(k)) return hist[cyc - lat_of(k)];
        return z;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_cr[k] = DEPTH; m_pkt[k] = 1'b0; m_nc[k] = 1'b0; m_ovf[k] = 1'b0;
        end
        cyc = 0;
    endtask

    // Monitor rules applied to the events of the cycle that is ending.
    task automatic model_edge();
        in_t e;
        bit s, c;
        for (int k = 0; k < 3; k++) begin
            e = delayed(k);
            s = hist[cyc].send;
            c = e.credit;
            if (s && !c) begin
                if (m_cr[k] == 0) m_nc[k] = 1'b1;
                else m_cr[k] = m_cr[k] - 1;
            end else if (c && !s) begin
                if (m_cr[k] == DEPTH) m_ovf[k] = 1'b1;
                else m_cr[k] = m_cr[k] + 1;
            end
            if (s) m_pkt[k] = !hist[cyc].tail;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t cyc=%0d)", nm, act, exp, $time, cyc);
        end
    endtask

    task automatic check_all();
        in_t e;
        for (int k = 0; k < 3; k++) begin
            e = delayed(k);
            chk($sformatf("send_out[L%0d]", lat_of(k)), 64'(o_send[k]), 64'(e.send));
            chk($sformatf("data_out[L%0d]", lat_of(k)), o_data[k], e.data);
            chk($sformatf("dest_out[L%0d]", lat_of(k)), 64'(o_dest[k]), 64'(e.dest));
            chk($sformatf("tail_out[L%0d]", lat_of(k)), 64'(o_tail[k]), 64'(e.tail));
            chk($sformatf("credit_out[L%0d]", lat_of(k)), 64'(o_cred[k]), 64'(e.credit));
            chk($sformatf("credits_avail[L%0d]", lat_of(k)), 64'(ca[k]), MON_EN ? 64'(m_cr[k]) : 64'(DEPTH));
            chk($sformatf("pkt_open[L%0d]", lat_of(k)), 64'(pk[k]), MON_EN ? 64'(m_pkt[k]) : 64'd0);
            chk($sformatf("err_no_credit[L%0d]", lat_of(k)), 64'(nc[k]), MON_EN ? 64'(m_nc[k]) : 64'd0);
            chk($sformatf("err_credit_ovf[L%0d]", lat_of(k)), 64'(ov[k]), MON_EN ? 64'(m_ovf[k]) : 64'd0);
        end
    endtask

    // One link cycle: apply inputs, check, clock, advance the model.
    task automatic step(input logic s, input logic t, input logic c,
                        input logic [63:0] d, input logic [3:0] ds);
        send_in = s; tail_in = t; credit_in = c; data_in = d; dest_in = ds;
        hist[cyc] = '{data: d, dest: ds, tail: t, send: s, credit: c};
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    // Reset dropped between clock edges; pipelined outputs must clear at once.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        send_in = 1'b0; tail_in = 1'b0; credit_in = 1'b0; data_in = '0; dest_in = '0;
        #1;
        for (int k = 1; k < 3; k++) begin
            chk($sformatf("async_send[L%0d]", lat_of(k)), 64'(o_send[k]), 64'd0);
            chk($sformatf("async_data[L%0d]", lat_of(k)), o_data[k], 64'd0);
            chk($sformatf("async_credit[L%0d]", lat_of(k)), 64'(o_cred[k]), 64'd0);
            chk($sformatf("async_ca[L%0d]", lat_of(k)), 64'(ca[k]), 64'(DEPTH));
            chk($sformatf("async_err[L%0d]", lat_of(k)), 64'({nc[k], ov[k], pk[k]}), 64'd0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       s, t, c;
        logic [1:0] e_ca;
        logic       e_pkt, e_nc, e_ovf;
    } vec_t;

    vec_t tbl [15];

    initial begin
        // send, tail, credit -> expected monitor of the latency-0 link after the edge
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1};

        // Power-on reset values.
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_send[L%0d]", lat_of(k)), 64'(o_send[k]), 64'd0);
            chk($sformatf("rst_data[L%0d]", lat_of(k)), o_data[k], 64'd0);
            chk($sformatf("rst_credit[L%0d]", lat_of(k)), 64'(o_cred[k]), 64'd0);
            chk($sformatf("rst_ca[L%0d]", lat_of(k)), 64'(ca[k]), 64'(DEPTH));
            chk($sformatf("rst_flags[L%0d]", lat_of(k)), 64'({pk[k], nc[k], ov[k]}), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Latency: flit at cycle 0 and credit at cycle 5 reach the L3 outputs at 3 and 8 only.
        for (int c = 0; c < 12; c++) begin
            step(c == 0, 1'b1, c == 5, (c == 0) ? 64'hA5 : 64'h0, 4'h0);
            chk("lat3_send", 64'(o_send[1]), (cyc == 3) ? 64'd1 : 64'd0);
            chk("lat3_data", o_data[1], (cyc == 3) ? 64'hA5 : 64'h0);
            chk("lat3_credit", 64'(o_cred[1]), (cyc == 8) ? 64'd1 : 64'd0);
        end

        // Credit accounting and violations, table-driven on the latency-0 link.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].s, tbl[i].t, tbl[i].c, 64'(i) * 64'h0101_0101_0101_0101, 4'(i));
            chk($sformatf("tbl%0d_ca", i), 64'(ca[0]), MON_EN ? 64'(tbl[i].e_ca) : 64'(DEPTH));
            chk($sformatf("tbl%0d_pkt", i), 64'(pk[0]), MON_EN ? 64'(tbl[i].e_pkt) : 64'd0);
            chk($sformatf("tbl%0d_nc", i), 64'(nc[0]), MON_EN ? 64'(tbl[i].e_nc) : 64'd0);
            chk($sformatf("tbl%0d_ovf", i), 64'(ov[0]), MON_EN ? 64'(tbl[i].e_ovf) : 64'd0);
        end

        // Framing: 4-flit packet, then a single-flit packet.
        do_reset();
        for (int f = 0; f < 4; f++) begin
            step(1'b1, f == 3, 1'b0, 64'hF00 + 64'(f), 4'h3);
            chk($sformatf("frame4_pkt%0d", f), 64'(pk[0]), (MON_EN && f != 3) ? 64'd1 : 64'd0);
        end
        step(1'b0, 1'b0, 1'b0, 64'h0, 4'h0);
        chk("frame4_idle", 64'(pk[0]), 64'd0);
        step(1'b1, 1'b1, 1'b0, 64'hABC, 4'h1);
        chk("frame1_pkt", 64'(pk[0]), 64'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 4), {$urandom, $urandom}, 4'($urandom));
        end

        // Reset mid-flight on the 4-deep link with flits in the slices.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, {$urandom, $urandom}, 4'($urandom));
        end
        chk("pre_reset_send_L4", 64'(o_send[2]), 64'd1);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 64'h0, 4'h0);
            chk("post_reset_nostale_L4", 64'(o_send[2]), 64'd0);
        end
        chk("post_reset_ca_L4", 64'(ca[2]), 64'(DEPTH));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_pipeline_link.md
# noc_pipeline_link

- Registered, credit-based link stage placed between a router output port and the input port of the neighbouring router.
- Forward path: `NUM_PIPELINE` register slices carry flit, destination, tail and send.
- Reverse path: an equal number of slices carry credit.
- Optional monitor on the upstream side tracks credits and packet framing, and flags protocol violations.

## Interface
Parameters:
- `NUM_PIPELINE`, 0: register slices in each direction. 0 = combinational passthrough.
- `FLIT_WIDTH`, 64: flit payload width.
- `DEST_WIDTH`, 4: destination field width.
- `FLIT_BUFFER_DEPTH`, 1: receiver input buffer depth. This is the credit count the monitor starts with.

Ports:
- `clk_noc`  in  1  link clock. Single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `data_in`  in  FLIT_WIDTH  flit from upstream router.
- `dest_in`  in  DEST_WIDTH  destination from upstream.
- `is_tail_in`  in  1  last flit of packet.
- `send_in`  in  1  flit valid, one cycle per flit.
- `credit_out`  out  1  credit returned to upstream router.
- `data_out`  out  FLIT_WIDTH  flit to downstream router.
- `dest_out`  out  DEST_WIDTH  destination to downstream.
- `is_tail_out`  out  1  tail to downstream.
- `send_out`  out  1  flit valid to downstream.
- `credit_in`  in  1  credit from downstream router.
- `credits_avail`  out  $clog2(FLIT_BUFFER_DEPTH+1)  monitor: upstream credits remaining.
- `pkt_open`  out  1  monitor: a packet has started and its tail has not yet been seen.
- `err_no_credit`  out  1  monitor: sticky error, flit sent with zero credits.
- `err_credit_ovf`  out  1  monitor: sticky error, credit returned while the counter is already full.

## Operation
Forward path:
- `{data, dest, is_tail, send}` passes through an N-deep shift register.
- Every slice advances every cycle. There are no stalls; flow control is entirely credit-based.
- With `NUM_PIPELINE`=0, each output is a direct wire from its input.

Reverse path:
- `credit_in` passes through an N-deep shift register to `credit_out`.

Monitor (all events are sampled at the upstream side, using `send_in` and `credit_out`):
- `credits_avail` resets to `FLIT_BUFFER_DEPTH`.
- `send_in` alone: decrement by 1.
- `credit_out` alone: increment by 1.
- Both in the same cycle: no change.
- `send_in` while `credits_avail`==0 (and no credit the same cycle):
  - set `err_no_credit`;
  - the counter saturates at 0 and does not wrap.
- `credit_out` while `credits_avail`==`FLIT_BUFFER_DEPTH` (and no send the same cycle):
  - set `err_credit_ovf`;
  - the counter saturates at `FLIT_BUFFER_DEPTH`.
- `pkt_open` is set on a `send_in` with `is_tail_in`=0 and cleared on a `send_in` with `is_tail_in`=1. A single-flit packet leaves it at 0.
- Error flags are sticky until reset.

## Timing
- Forward latency is exactly `NUM_PIPELINE` cycles from `send_in` to `send_out`. Data, dest and tail stay aligned with send.
- Credit latency is exactly `NUM_PIPELINE` cycles from `credit_in` to `credit_out`.
- Back-to-back flits, one per cycle, are sustained indefinitely. A gap on the input appears unchanged on the output.
- Reset values:
  - all slice registers, and therefore `send_out`, `credit_out`, `data_out`, `dest_out` and `is_tail_out`, are 0;
  - `credits_avail` = `FLIT_BUFFER_DEPTH`;
  - `pkt_open` = 0 and both error flags = 0.
- Reset asserted mid-operation: in-flight flits and credits are dropped immediately (asynchronously). Outputs return to their reset values without waiting for a clock edge.
- Monitor outputs are registered and update one cycle after the sampled event.
- With `NUM_PIPELINE`=0, the data path has no registers. Only the monitor is clocked.

## Configuration
`NOC_LINK_MONITOR_EN`:
- Defined: the credit counter, packet tracker and sticky error flags are implemented as described above.
- Undefined: none of the monitor logic is built. `credits_avail` is tied to `FLIT_BUFFER_DEPTH`, and `pkt_open`, `err_no_credit` and `err_credit_ovf` are tied to 0.
- The data and credit paths behave identically with or without the macro.

## Test plan
- Latency, `NUM_PIPELINE`=3: `send_in`=1, `data_in`=0xA5 at cycle 0 -> `send_out`=1, `data_out`=0xA5 at cycle 3 only. Likewise `credit_in` at cycle 5 -> `credit_out` at cycle 8 only.
- Passthrough, `NUM_PIPELINE`=0: random `send_in`/`data_in`/`credit_in` each cycle -> outputs equal inputs in the same cycle.
- Credit accounting, `FLIT_BUFFER_DEPTH`=2, monitor enabled: send, send -> `credits_avail`=0. Return one credit -> 1. Simultaneous send and credit -> stays 1. No error flags set.
- Credit violation, depth 2: three sends with no credits -> `err_no_credit`=1, `credits_avail`=0. Then three credits -> `err_credit_ovf`=1, `credits_avail`=2. Both flags remain 1 until reset.
- Framing: 4-flit packet (tail on 4th) -> `pkt_open`=1 after flit 1 and 0 after flit 4. A 1-flit packet leaves `pkt_open`=0.
- Reset mid-flight, `NUM_PIPELINE`=4: two flits in the slices, then `rst_n` dropped between clock edges -> `send_out`=0 immediately. After release, no stale flit ever appears and `credits_avail`=`FLIT_BUFFER_DEPTH`.
